// File: rtl/mmtiled_c_job_scheduler_pkg.sv
// Shared definitions for the tiled matrix-multiply C-job scheduler:
// grid/tile constants, the C-job payload and the scheduler state encoding.
package mmtiled_c_job_scheduler_pkg;

  localparam int unsigned NUM_X_CU_GLOBAL             = 2;
  localparam int unsigned NUM_Y_CU_GLOBAL             = 2;
  localparam int unsigned TILE_DIM                    = 16;
  localparam int unsigned DIM_W                       = 32;
  localparam int unsigned ADDR_W                      = 64;
  localparam int unsigned DATA_SIZE_READ              = 4;
  localparam int unsigned CU_MATRIX_C_JOB_BUFFER_SIZE = 64;
  localparam int unsigned MAX_OUTSTANDING             = CU_MATRIX_C_JOB_BUFFER_SIZE;

  typedef struct packed {
    logic [DIM_W-1:0]  tile_row;
    logic [DIM_W-1:0]  tile_col;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] c_addr;
  } matrix_c_job_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mmtiled_c_job_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at a registered pointer that
// moves to one past the winner whenever a grant is consumed.
module mmtiled_rr_arbiter #(
  parameter int unsigned NUM_CU = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CU-1:0] req,
  input  logic              advance,
  output logic [NUM_CU-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;
  logic [31:0]      idx_wide;
  logic             found;

  // First requester at or after the pointer, wrapping at NUM_CU
  always_comb begin
    grant    = '0;
    win_idx  = '0;
    idx      = '0;
    idx_wide = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_CU; i++) begin
      idx_wide = 32'(ptr_q) + i;
      if (idx_wide >= NUM_CU) idx_wide = idx_wide - NUM_CU;
      idx = PTR_W'(idx_wide);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (32'(win_idx) == NUM_CU - 1) ? '0 : PTR_W'(win_idx + 1'b1);
    end
  end

endmodule

// File: rtl/mmtiled_c_job_scheduler.sv
// Generates one job per C tile in row-major order, dispatches jobs to the CU
// array through a round-robin arbiter and tracks outstanding work to completion.
module mmtiled_c_job_scheduler
  import mmtiled_c_job_scheduler_pkg::*;
#(
  parameter int unsigned NUM_X_CU        = mmtiled_c_job_scheduler_pkg::NUM_X_CU_GLOBAL,
  parameter int unsigned NUM_Y_CU        = mmtiled_c_job_scheduler_pkg::NUM_Y_CU_GLOBAL,
  parameter int unsigned TILE_DIM        = mmtiled_c_job_scheduler_pkg::TILE_DIM,
  parameter int unsigned DIM_W           = mmtiled_c_job_scheduler_pkg::DIM_W,
  parameter int unsigned ELEM_BYTES      = mmtiled_c_job_scheduler_pkg::DATA_SIZE_READ,
  parameter int unsigned MAX_OUTSTANDING = mmtiled_c_job_scheduler_pkg::MAX_OUTSTANDING
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_in,
  input  logic [DIM_W-1:0]             cfg_m_in,
  input  logic [DIM_W-1:0]             cfg_n_in,
  input  logic [DIM_W-1:0]             cfg_k_in,
  input  logic [ADDR_W-1:0]            cfg_a_base_in,
  input  logic [ADDR_W-1:0]            cfg_b_base_in,
  input  logic [ADDR_W-1:0]            cfg_c_base_in,
  input  logic [NUM_X_CU*NUM_Y_CU-1:0] job_ready_in,
  output logic [NUM_X_CU*NUM_Y_CU-1:0] job_grant_out,
  output logic                         job_valid_out,
  output logic [DIM_W-1:0]             job_tile_row_out,
  output logic [DIM_W-1:0]             job_tile_col_out,
  output logic [ADDR_W-1:0]            job_a_addr_out,
  output logic [ADDR_W-1:0]            job_b_addr_out,
  output logic [ADDR_W-1:0]            job_c_addr_out,
  input  logic [NUM_X_CU*NUM_Y_CU-1:0] job_done_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out,
  output logic [DIM_W-1:0]             jobs_issued_out,
  output logic [DIM_W-1:0]             jobs_done_out
);

  localparam int unsigned NUM_CU     = NUM_X_CU * NUM_Y_CU;
  localparam int unsigned TILE_SHIFT = $clog2(TILE_DIM);
  localparam int unsigned ROW_SHIFT  = $clog2(TILE_DIM * ELEM_BYTES);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W      = $clog2(NUM_CU + 1);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(TILE_DIM * ELEM_BYTES);

  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  tiles_m_q, tiles_n_q;
  logic [ADDR_W-1:0] a_stride_q, c_stride_q, b_base_q, gen_c_row_q;
  matrix_c_job_t     gen_q, job_q;
  logic              gen_pending_q, job_valid_q;
  logic [OUT_W-1:0]  outstanding_q;
  logic [DIM_W-1:0]  issued_q, done_cnt_q;
  logic              busy_q, done_q, error_q;

  logic              start_ok, transfer, can_load, over;
  logic [CNT_W-1:0]  done_pop;
  logic [31:0]       avail, accepted, out_next;
  logic [DIM_W:0]    done_sum, m_round, n_round;

  // Next state plus handshake, load and completion bookkeeping
  always_comb begin
    state_d  = state_q;
    start_ok = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    transfer = job_valid_q && (|job_ready_in);
    can_load = ((state_q == ST_SETUP) || (state_q == ST_ISSUE)) && gen_pending_q &&
               (!job_valid_q || transfer) &&
               ((32'(outstanding_q) + 32'(job_valid_q)) < MAX_OUTSTANDING);
    done_pop = '0;
    for (int unsigned i = 0; i < NUM_CU; i++) done_pop = done_pop + CNT_W'(job_done_in[i]);
    avail    = 32'(outstanding_q) + 32'(transfer);
    over     = 32'(done_pop) > avail;
    accepted = over ? avail : 32'(done_pop);
    out_next = avail - accepted;
    done_sum = {1'b0, done_cnt_q} + (DIM_W+1)'(accepted);
    m_round  = {1'b0, cfg_m_in} + (DIM_W+1)'(TILE_DIM - 1);
    n_round  = {1'b0, cfg_n_in} + (DIM_W+1)'(TILE_DIM - 1);
    case (state_q)
      ST_IDLE, ST_DONE: if (start_in) state_d = ST_SETUP;
      ST_SETUP:         state_d = gen_pending_q ? ST_ISSUE : ST_DONE;
      ST_ISSUE:         if (!gen_pending_q && transfer) state_d = ST_DRAIN;
      ST_DRAIN:         if (outstanding_q == '0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tiles_m_q     <= '0;
      tiles_n_q     <= '0;
      a_stride_q    <= '0;
      c_stride_q    <= '0;
      b_base_q      <= '0;
      gen_c_row_q   <= '0;
      gen_q         <= '0;
      job_q         <= '0;
      gen_pending_q <= 1'b0;
      job_valid_q   <= 1'b0;
      outstanding_q <= '0;
      issued_q      <= '0;
      done_cnt_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_SETUP) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      done_q <= (state_d == ST_DONE);
      if (start_ok) begin
        // Tile counts and strides are derived here so SETUP can load the first job
        tiles_m_q     <= DIM_W'(m_round >> TILE_SHIFT);
        tiles_n_q     <= DIM_W'(n_round >> TILE_SHIFT);
        a_stride_q    <= ADDR_W'(cfg_k_in) << ROW_SHIFT;
        c_stride_q    <= ADDR_W'(cfg_n_in) << ROW_SHIFT;
        b_base_q      <= cfg_b_base_in;
        gen_c_row_q   <= cfg_c_base_in;
        gen_q         <= '{tile_row: '0, tile_col: '0, a_addr: cfg_a_base_in,
                           b_addr: cfg_b_base_in, c_addr: cfg_c_base_in};
        gen_pending_q <= (cfg_m_in != '0) && (cfg_n_in != '0) && (cfg_k_in != '0);
        job_valid_q   <= 1'b0;
        outstanding_q <= '0;
        issued_q      <= '0;
        done_cnt_q    <= '0;
        error_q       <= 1'b0;
      end else begin
        if (over) error_q <= 1'b1;
        outstanding_q <= OUT_W'(out_next);
        if (transfer && (issued_q != '1)) issued_q <= issued_q + 1'b1;
        done_cnt_q <= done_sum[DIM_W] ? '1 : done_sum[DIM_W-1:0];
        if (can_load) begin
          job_q       <= gen_q;
          job_valid_q <= 1'b1;
          // Column first; on wrap step every row-dependent address by its stride
          if (gen_q.tile_col == tiles_n_q - 1'b1) begin
            gen_q.tile_col <= '0;
            gen_q.b_addr   <= b_base_q;
            if (gen_q.tile_row == tiles_m_q - 1'b1) begin
              gen_pending_q <= 1'b0;
            end else begin
              gen_q.tile_row <= gen_q.tile_row + 1'b1;
              gen_q.a_addr   <= gen_q.a_addr + a_stride_q;
              gen_q.c_addr   <= gen_c_row_q + c_stride_q;
              gen_c_row_q    <= gen_c_row_q + c_stride_q;
            end
          end else begin
            gen_q.tile_col <= gen_q.tile_col + 1'b1;
            gen_q.b_addr   <= gen_q.b_addr + COL_STEP;
            gen_q.c_addr   <= gen_q.c_addr + COL_STEP;
          end
        end else if (transfer) begin
          job_valid_q <= 1'b0;
        end
      end
    end
  end

  mmtiled_rr_arbiter #(.NUM_CU(NUM_CU)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({NUM_CU{job_valid_q}} & job_ready_in),
    .advance (transfer),
    .grant   (job_grant_out)
  );

  assign job_valid_out    = job_valid_q;
  assign job_tile_row_out = job_q.tile_row;
  assign job_tile_col_out = job_q.tile_col;
  assign job_a_addr_out   = job_q.a_addr;
  assign job_b_addr_out   = job_q.b_addr;
  assign job_c_addr_out   = job_q.c_addr;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign error_out        = error_q;
  assign jobs_issued_out  = issued_q;
  assign jobs_done_out    = done_cnt_q;

endmodule

// File: tb/tb_mmtiled_c_job_scheduler.sv
// Directed bench for the C-job scheduler: ordering, addresses, arbitration,
// stalls, outstanding-cap back-pressure, error and reset behaviour.
module tb_mmtiled_c_job_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic [31:0] cfg_m_in = '0, cfg_n_in = '0, cfg_k_in = '0;
  logic [63:0] cfg_a_base_in = 64'h1000, cfg_b_base_in = 64'h2000, cfg_c_base_in = 64'h3000;
  logic [3:0]  job_ready_in = '0;
  logic [3:0]  job_done_in = '0;
  logic [3:0]  job_grant_out;
  logic        job_valid_out, busy_out, done_out, error_out;
  logic [31:0] job_tile_row_out, job_tile_col_out, jobs_issued_out, jobs_done_out;
  logic [63:0] job_a_addr_out, job_b_addr_out, job_c_addr_out;

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [3:0]  grant;
  } xfer_t;

  xfer_t xq[$];
  int    valid_cnt = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    b0;
  int    v0;

  mmtiled_c_job_scheduler dut (
    .clock(clock), .reset(reset), .start_in(start_in),
    .cfg_m_in(cfg_m_in), .cfg_n_in(cfg_n_in), .cfg_k_in(cfg_k_in),
    .cfg_a_base_in(cfg_a_base_in), .cfg_b_base_in(cfg_b_base_in), .cfg_c_base_in(cfg_c_base_in),
    .job_ready_in(job_ready_in), .job_grant_out(job_grant_out), .job_valid_out(job_valid_out),
    .job_tile_row_out(job_tile_row_out), .job_tile_col_out(job_tile_col_out),
    .job_a_addr_out(job_a_addr_out), .job_b_addr_out(job_b_addr_out), .job_c_addr_out(job_c_addr_out),
    .job_done_in(job_done_in), .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .jobs_issued_out(jobs_issued_out), .jobs_done_out(jobs_done_out)
  );

  always #5 clock = ~clock;

  // Record every handshake mid-cycle, when inputs and outputs are settled
  always @(negedge clock) begin
    if (!reset && job_valid_out) valid_cnt <= valid_cnt + 1;
    if (!reset && job_valid_out && (|job_ready_in))
      xq.push_back('{row: job_tile_row_out, col: job_tile_col_out, a: job_a_addr_out,
                     b: job_b_addr_out, c: job_c_addr_out, grant: job_grant_out});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_start(input logic [31:0] m, input logic [31:0] n, input logic [31:0] k);
    cfg_m_in = m; cfg_n_in = n; cfg_k_in = k;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && xq.size() < target; i++) step();
    check(tag, 64'(xq.size()), 64'(target));
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && !done_out; i++) step();
    check(tag, 64'(done_out), 64'd1);
  endtask

  task automatic pulse_done(input logic [3:0] v);
    job_done_in = v;
    step();
    job_done_in = '0;
  endtask

  initial begin
    logic [31:0] exp_row [4];
    logic [31:0] exp_col [4];
    logic [3:0]  exp_gnt [4];
    exp_row = '{0, 0, 1, 1};
    exp_col = '{0, 1, 0, 1};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    step(); step();
    reset = 1'b0;
    check("rst_busy", 64'(busy_out), 0);
    check("rst_done", 64'(done_out), 0);
    check("rst_valid", 64'(job_valid_out), 0);
    check("rst_issued", 64'(jobs_issued_out), 0);

    // 2x2 tiles, all CUs ready
    job_ready_in = 4'hF;
    b0 = xq.size();
    run_start(32, 32, 32);
    check("t1_setup_valid", 64'(job_valid_out), 0);
    check("t1_setup_busy", 64'(busy_out), 1);
    step();
    check("t1_first_valid", 64'(job_valid_out), 1);
    wait_xfers(b0 + 4, 10, "t1_xfers");
    for (int i = 0; i < 4; i++) begin
      if (b0 + i < xq.size()) begin
        check("t1_row", 64'(xq[b0+i].row), 64'(exp_row[i]));
        check("t1_col", 64'(xq[b0+i].col), 64'(exp_col[i]));
        check("t1_grant", 64'(xq[b0+i].grant), 64'(exp_gnt[i]));
      end
    end
    if (b0 + 3 < xq.size()) begin
      check("t1_a11", xq[b0+3].a, 64'h1800);
      check("t1_b11", xq[b0+3].b, 64'h2040);
      check("t1_c11", xq[b0+3].c, 64'h3840);
    end
    check("t1_drain_done", 64'(done_out), 0);
    pulse_done(4'hF);
    wait_done(10, "t1_done");
    check("t1_jobs_done", 64'(jobs_done_out), 4);
    check("t1_jobs_issued", 64'(jobs_issued_out), 4);
    check("t1_busy", 64'(busy_out), 0);

    // Ragged M: two row tiles, one column tile
    b0 = xq.size();
    run_start(17, 16, 8);
    wait_xfers(b0 + 2, 10, "t2_xfers");
    repeat (5) step();
    check("t2_exact", 64'(xq.size()), 64'(b0 + 2));
    if (b0 + 1 < xq.size()) begin
      check("t2_row1", 64'(xq[b0+1].row), 1);
      check("t2_col1", 64'(xq[b0+1].col), 0);
      check("t2_a1", xq[b0+1].a, 64'h1200);
      check("t2_c1", xq[b0+1].c, 64'h3400);
    end
    pulse_done(4'b0011);
    wait_done(10, "t2_done");
    check("t2_jobs_done", 64'(jobs_done_out), 2);

    // Only CU2 ready, then a 10-cycle stall with nobody ready
    job_ready_in = 4'b0100;
    b0 = xq.size();
    run_start(32, 32, 32);
    wait_xfers(b0 + 2, 20, "t4_xfers2");
    job_ready_in = 4'b0000;
    #1;
    check("t4_grant_idle", 64'(job_grant_out), 0);
    repeat (10) step();
    check("t4_no_xfer", 64'(xq.size()), 64'(b0 + 2));
    check("t4_hold_valid", 64'(job_valid_out), 1);
    check("t4_hold_row", 64'(job_tile_row_out), 1);
    check("t4_hold_col", 64'(job_tile_col_out), 0);
    check("t4_hold_a", job_a_addr_out, 64'h1800);
    check("t4_hold_b", job_b_addr_out, 64'h2000);
    check("t4_hold_c", job_c_addr_out, 64'h3800);
    job_ready_in = 4'b0100;
    wait_xfers(b0 + 4, 20, "t4_xfers4");
    for (int i = 0; i < 4; i++)
      if (b0 + i < xq.size()) check("t4_grant", 64'(xq[b0+i].grant), 64'h4);
    pulse_done(4'hF);
    wait_done(10, "t4_done");

    // 9x9 tiles with no completions: outstanding cap holds at 64
    job_ready_in = 4'hF;
    b0 = xq.size();
    run_start(144, 144, 16);
    repeat (90) step();
    check("t5_cap_xfers", 64'(xq.size()), 64'(b0 + 64));
    check("t5_cap_issued", 64'(jobs_issued_out), 64);
    check("t5_cap_valid", 64'(job_valid_out), 0);
    pulse_done(4'b0001);
    wait_xfers(b0 + 65, 2, "t5_65th");
    job_ready_in = 4'b0000;
    pulse_done(4'b0001);
    step(); step();
    check("t5_refill_valid", 64'(job_valid_out), 1);
    check("t5_issued65", 64'(jobs_issued_out), 65);
    job_ready_in = 4'hF;
    job_done_in = 4'b0111;
    step();
    job_ready_in = 4'b0000;
    job_done_in = 4'b0000;
    check("t5_issued66", 64'(jobs_issued_out), 66);
    check("t5_done5", 64'(jobs_done_out), 5);
    check("t5_no_err", 64'(error_out), 0);

    // Reset in the middle of ISSUE
    reset = 1'b1;
    step();
    job_ready_in = 4'hF;
    #1;
    check("rst_mid_busy", 64'(busy_out), 0);
    check("rst_mid_valid", 64'(job_valid_out), 0);
    check("rst_mid_grant", 64'(job_grant_out), 0);
    check("rst_mid_issued", 64'(jobs_issued_out), 0);
    check("rst_mid_jdone", 64'(jobs_done_out), 0);
    check("rst_mid_row", 64'(job_tile_row_out), 0);
    check("rst_mid_c", job_c_addr_out, 0);
    reset = 1'b0;
    step();

    // Completion with nothing outstanding
    pulse_done(4'b0001);
    check("err_set", 64'(error_out), 1);
    check("err_jdone", 64'(jobs_done_out), 0);

    // Zero-size run: DONE two cycles after start, no job ever valid
    v0 = valid_cnt;
    run_start(0, 32, 32);
    check("t3_done_t1", 64'(done_out), 0);
    check("t3_err_clr", 64'(error_out), 0);
    step();
    check("t3_done_t2", 64'(done_out), 1);
    check("t3_busy_t2", 64'(busy_out), 0);
    repeat (3) step();
    check("t3_never_valid", 64'(valid_cnt), 64'(v0));
    check("t3_issued", 64'(jobs_issued_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmtiled_c_job_scheduler.md
Name: mmtiled_c_job_scheduler

Overview:
- Sequences a tiled matrix multiply C = A x B by generating one job per C-tile: tile row, tile column, and A/B/C base byte addresses.
- Dispatches each job to one of NUM_X_CU x NUM_Y_CU compute units through round-robin arbitration.
- Tracks outstanding jobs against the C job buffer limit and signals completion.
- Sits between the mmtiled CU control front end (start and config) and the CU array.

Parameters:
- NUM_X_CU, 2 (NUM_X_CU_GLOBAL): CU grid columns.
- NUM_Y_CU, 2 (NUM_Y_CU_GLOBAL): CU grid rows. NUM_CU = NUM_X_CU*NUM_Y_CU.
- TILE_DIM, 16: tile edge in elements. Must be a power of 2.
- DIM_W, 32: matrix dimension and tile index width.
- ELEM_BYTES, 4 (DATA_SIZE_READ): element size in bytes.
- MAX_OUTSTANDING, 64 (CU_MATRIX_C_JOB_BUFFER_SIZE): cap on issued-minus-completed jobs.

Ports:
- clock in 1: single clock.
- reset in 1: synchronous, active-high.
- start_in in 1: one-cycle start pulse.
- cfg_m_in / cfg_n_in / cfg_k_in in DIM_W each: M, N, K in elements. A is MxK, B is KxN, C is MxN, all row-major.
- cfg_a_base_in / cfg_b_base_in / cfg_c_base_in in 64 each: byte base addresses.
- job_ready_in in NUM_CU: per-CU ready.
- job_grant_out out NUM_CU: one-hot target of the current job.
- job_valid_out out 1: job register holds a valid job.
- job_tile_row_out / job_tile_col_out out DIM_W each: tile indices.
- job_a_addr_out / job_b_addr_out / job_c_addr_out out 64 each: tile byte addresses.
- job_done_in in NUM_CU: per-CU one-cycle completion pulses. Several bits may be set in one cycle.
- busy_out out 1: run in progress.
- done_out out 1: run finished.
- error_out out 1: sticky protocol error.
- jobs_issued_out / jobs_done_out out DIM_W each: run counters.

Behaviour:
- Reset: every output and counter is 0, the FSM is IDLE, the RR pointer is 0. Reset mid-run aborts: all outputs are 0 on the next cycle and any pending job is dropped.
- FSM states: IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE/DONE to SETUP on start_in:
  - Latch the config.
  - Clear done_out, error_out and both counters.
  - start_in is ignored in SETUP, ISSUE and DRAIN.
- SETUP (1 cycle):
  - tiles_m = ceil(M/TILE_DIM) and tiles_n = ceil(N/TILE_DIM), computed by add and shift.
  - a_row_stride = K<<log2(TILE_DIM*ELEM_BYTES).
  - c_row_stride = N<<log2(TILE_DIM*ELEM_BYTES).
  - col_step = TILE_DIM*ELEM_BYTES.
  - If M, N or K is 0, go to DONE with zero jobs. Otherwise go to ISSUE.
  - Latency: start_in at cycle t gives the first job_valid_out at t+2.
- Job order: row-major over tiles, starting at (0,0). The column increments first; at tiles_n-1 it wraps to 0 and the row increments.
- Job addresses, formed by incremental adds only (no multipliers):
  - A = a_base + row*a_row_stride.
  - B = b_base + col*col_step.
  - C = c_base + row*c_row_stride + col*col_step.
- Job register handshake:
  - Transfer when job_valid_out && |job_ready_in.
  - job_grant_out = combinational round-robin pick among the ready CUs, starting at the RR pointer. It is 0 when job_valid_out = 0.
  - After a transfer the RR pointer becomes granted index + 1, wrapping at NUM_CU.
  - The register refills in the same cycle as a transfer, so sustained throughput is 1 job/cycle.
  - While no CU is ready, every job field holds stable.
- Outstanding count:
  - outstanding = issued - completed.
  - The generator stalls loading while outstanding + job_valid_out == MAX_OUTSTANDING.
  - Each cycle: outstanding += transfer - popcount(job_done_in).
- ISSUE to DRAIN after the last job transfers. DRAIN to DONE when outstanding == 0.
- DONE: done_out = 1 and busy_out = 0, held until the next start_in. busy_out = 1 in SETUP, ISSUE and DRAIN.
- Errors: error_out sets (sticky) if popcount(job_done_in) exceeds outstanding + transfer. The excess pulses are ignored and outstanding saturates at 0.
- Counter widths: jobs_issued_out / jobs_done_out saturate at all-ones.

Decomposition:
- Add to GLOBALS_CU_PKG:
  - TILE_DIM.
  - The MatrixCJob struct {tile_row, tile_col, a_addr, b_addr, c_addr}.
  - The scheduler state enum.
  - MAX_OUTSTANDING alias.
- Sub-module mmtiled_rr_arbiter:
  - Parameter NUM_CU.
  - Inputs: req vector, ptr, advance.
  - Output: one-hot grant.
  - Pure round-robin with registered pointer.

Test Plan:
- M=N=K=32, a=0x1000, b=0x2000, c=0x3000, all ready:
  - 4 jobs (0,0),(0,1),(1,0),(1,1), granted to CU0..CU3.
  - Job (1,1): a=0x1800, b=0x2040, c=0x3840.
  - After 4 done pulses, done_out=1 and jobs_done_out=4.
- M=17, N=16, K=8 -> exactly 2 jobs, (0,0) and (1,0); the second has c=c_base+0x400.
- M=0 with start at t -> done_out=1 at t+2; job_valid_out never asserts; jobs_issued_out=0.
- Only CU2 ready:
  - Every grant is 0b0100.
  - Then all ready deasserted for 10 cycles: job fields stable and no transfer.
- M=N=144, K=16, no done pulses:
  - Exactly 64 transfers, then stall.
  - One done pulse -> the 65th transfers within 2 cycles.
- Edge cases:
  - 3 done pulses in the same cycle as a transfer -> outstanding drops by 2.
  - A done pulse with outstanding=0 and no transfer -> error_out=1.
  - reset asserted mid-ISSUE -> all outputs 0 on the next cycle.
